// File: rtl/alu_share_if.sv
// Request, response and ALU-side signals of the shared-ALU controller.
// slave: the controller; master: requesters plus the combinational ALU.
interface alu_share_if;
   logic        req0_valid;
   logic        req1_valid;
   logic        req0_ready;
   logic        req1_ready;
   logic [31:0] req0_src0;
   logic [31:0] req0_src1;
   logic [31:0] req1_src0;
   logic [31:0] req1_src1;
   logic [4:0]  req0_op;
   logic [4:0]  req1_op;
   logic        rsp0_valid;
   logic        rsp1_valid;
   logic        rsp0_ready;
   logic        rsp1_ready;
   logic [31:0] rsp_res;
   logic        rsp_err;
   logic [31:0] alu_src0;
   logic [31:0] alu_src1;
   logic [4:0]  alu_op;
   logic [31:0] alu_res;

   modport slave (
      input  req0_valid, req1_valid, req0_src0, req0_src1, req1_src0, req1_src1,
      input  req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
      output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_res, rsp_err,
      output alu_src0, alu_src1, alu_op
   );

   modport master (
      output req0_valid, req1_valid, req0_src0, req0_src1, req1_src0, req1_src1,
      output req0_op, req1_op, rsp0_ready, rsp1_ready, alu_res,
      input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_res, rsp_err,
      input  alu_src0, alu_src1, alu_op
   );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters with round-robin
// arbitration. One operation per three cycles: accept, execute, respond.
//
// state | meaning
// IDLE  | waiting for a request; arbitration active, ready may be high
// EXEC  | captured operands drive the ALU; result latched at the edge
// RESP  | owner's response valid until its rsp ready is seen
module alu_share_ctrl #(
   parameter bit RR_INIT = 1'b0
) (
   input logic       clk,
   input logic       rst,
   alu_share_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t      state;
   logic        ptr;
   logic        owner;
   logic [31:0] src0_q;
   logic [31:0] src1_q;
   logic [4:0]  op_q;
   logic [31:0] res_q;
   logic        err_q;
   logic        rsp0_q;
   logic        rsp1_q;
   logic        grant0;
   logic        grant1;

   function automatic logic op_legal(input logic [4:0] op);
      logic ok;
      case (op)
         5'b00000, 5'b00010, 5'b00100, 5'b00101,
         5'b01001, 5'b01010, 5'b01011, 5'b01110,
         5'b01111, 5'b10000, 5'b10001, 5'b10010: ok = 1'b1;
         default:                                ok = 1'b0;
      endcase
      return ok;
   endfunction

   // Arbitration: a lone requester wins, a tie goes to the pointer's port.
   always_comb begin
      grant0 = bus.req0_valid & (~bus.req1_valid | ~ptr);
      grant1 = bus.req1_valid & (~bus.req0_valid |  ptr);
   end

   // Readies are held low during reset so nothing is handshaken then.
   assign bus.req0_ready = (state == IDLE) & grant0 & ~rst;
   assign bus.req1_ready = (state == IDLE) & grant1 & ~rst;

   assign bus.alu_src0   = src0_q;
   assign bus.alu_src1   = src1_q;
   assign bus.alu_op     = op_q;
   assign bus.rsp0_valid = rsp0_q;
   assign bus.rsp1_valid = rsp1_q;
   assign bus.rsp_res    = res_q;
   assign bus.rsp_err    = err_q;

   // Sequencer: capture, execute, hold response until the owner takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= RR_INIT;
         owner  <= 1'b0;
         src0_q <= '0;
         src1_q <= '0;
         op_q   <= '0;
         res_q  <= '0;
         err_q  <= 1'b0;
         rsp0_q <= 1'b0;
         rsp1_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (grant0 | grant1) begin
                  owner  <= grant1;
                  src0_q <= grant1 ? bus.req1_src0 : bus.req0_src0;
                  src1_q <= grant1 ? bus.req1_src1 : bus.req0_src1;
                  op_q   <= grant1 ? bus.req1_op   : bus.req0_op;
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res_q  <= op_legal(op_q) ? bus.alu_res : '0;
               err_q  <= ~op_legal(op_q);
               rsp0_q <= ~owner;
               rsp1_q <= owner;
               state  <= RESP;
            end
            RESP: begin
               if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
                  rsp0_q <= 1'b0;
                  rsp1_q <= 1'b0;
                  ptr    <= ~owner;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios followed by random traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_alu_share_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   alu_share_if bus ();

   alu_share_ctrl #(.RR_INIT(1'b0)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [4:0] legal_ops [12] = '{5'b00000, 5'b00010, 5'b00100, 5'b00101,
                                  5'b01001, 5'b01010, 5'b01011, 5'b01110,
                                  5'b01111, 5'b10000, 5'b10001, 5'b10010};

   function automatic bit is_legal(input logic [4:0] op);
      foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
      return 1'b0;
   endfunction

   // Stand-in ALU; illegal opcodes yield junk the controller must discard.
   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
      case (op)
         5'b00000: return a + b;
         5'b00010: return a - b;
         5'b00100: return {31'd0, $signed(a) < $signed(b)};
         5'b00101: return {31'd0, a < b};
         5'b01001: return a & b;
         5'b01010: return a | b;
         5'b01011: return a ^ b;
         5'b01110: return a << b[4:0];
         5'b01111: return a >> b[4:0];
         5'b10000: return $signed(a) >>> b[4:0];
         5'b10001: return a;
         5'b10010: return b;
         default:  return 32'hDEAD_BEEF;
      endcase
   endfunction

   always_comb bus.alu_res = alu_fn(bus.alu_src0, bus.alu_src1, bus.alu_op);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Requester-side stimulus state
   logic        p_valid [2] = '{1'b0, 1'b0};
   logic [31:0] p_src0  [2] = '{32'd0, 32'd0};
   logic [31:0] p_src1  [2] = '{32'd0, 32'd0};
   logic [4:0]  p_op    [2] = '{5'd0, 5'd0};
   logic        rr      [2] = '{1'b1, 1'b1};

   // Reference model: one operation in flight, aged 1 (executing) or 2 (responding)
   bit          m_busy  = 0;
   int          m_age   = 0;
   bit          m_owner = 0;
   bit          m_ptr   = 0;
   logic [31:0] m_src0  = 0;
   logic [31:0] m_src1  = 0;
   logic [4:0]  m_op    = 0;
   logic [31:0] m_res   = 0;
   bit          m_err   = 0;

   task automatic drive();
      bus.req0_valid = p_valid[0];
      bus.req1_valid = p_valid[1];
      bus.req0_src0  = p_src0[0];
      bus.req0_src1  = p_src1[0];
      bus.req1_src0  = p_src0[1];
      bus.req1_src1  = p_src1[1];
      bus.req0_op    = p_op[0];
      bus.req1_op    = p_op[1];
      bus.rsp0_ready = rr[0];
      bus.rsp1_ready = rr[1];
   endtask

   task automatic settle();
      drive();
      #1;
   endtask

   task automatic set_req(input int n, input logic [4:0] op,
                          input logic [31:0] a, input logic [31:0] b);
      p_valid[n] = 1'b1;
      p_op[n]    = op;
      p_src0[n]  = a;
      p_src1[n]  = b;
   endtask

   // One clock: check every output against the model, advance the model,
   // then retire requests the DUT accepted.
   task automatic cyc();
      bit g0, g1, resp, acc0, acc1;
      settle();
      g0 = !rst && !m_busy && p_valid[0] && (!p_valid[1] || !m_ptr);
      g1 = !rst && !m_busy && p_valid[1] && (!p_valid[0] ||  m_ptr);
      resp = m_busy && m_age == 2;
      chk("req0_ready", {31'd0, bus.req0_ready}, {31'd0, g0});
      chk("req1_ready", {31'd0, bus.req1_ready}, {31'd0, g1});
      chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, resp && !m_owner});
      chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, resp &&  m_owner});
      chk("alu_src0", bus.alu_src0, m_src0);
      chk("alu_src1", bus.alu_src1, m_src1);
      chk("alu_op", {27'd0, bus.alu_op}, {27'd0, m_op});
      if (resp) begin
         chk("rsp_res", bus.rsp_res, m_res);
         chk("rsp_err", {31'd0, bus.rsp_err}, {31'd0, m_err});
      end
      acc0 = bus.req0_valid && bus.req0_ready;
      acc1 = bus.req1_valid && bus.req1_ready;
      if (rst) begin
         m_busy = 0; m_age = 0; m_owner = 0; m_ptr = 0;
         m_src0 = 0; m_src1 = 0; m_op = 0; m_res = 0; m_err = 0;
      end else if (g0 || g1) begin
         m_owner = g1;
         m_src0  = p_src0[g1];
         m_src1  = p_src1[g1];
         m_op    = p_op[g1];
         m_busy  = 1;
         m_age   = 1;
      end else if (m_busy && m_age == 1) begin
         m_age = 2;
         m_err = !is_legal(m_op);
         m_res = m_err ? 32'd0 : alu_fn(m_src0, m_src1, m_op);
      end else if (resp && rr[m_owner]) begin
         m_busy = 0;
         m_ptr  = !m_owner;
      end
      @(negedge clk);
      if (acc0) p_valid[0] = 1'b0;
      if (acc1) p_valid[1] = 1'b0;
   endtask

   logic [31:0] held_res;

   initial begin
      drive();
      repeat (2) @(negedge clk);

      // Reset held with both requesting: nothing accepted, outputs zero
      set_req(0, 5'b00000, 32'd1, 32'd2);
      set_req(1, 5'b00000, 32'd3, 32'd4);
      rst = 1'b1;
      repeat (2) begin
         settle();
         chk("rst_rdy0", {31'd0, bus.req0_ready}, 32'd0);
         chk("rst_rdy1", {31'd0, bus.req1_ready}, 32'd0);
         chk("rst_res", bus.rsp_res, 32'd0);
         chk("rst_err", {31'd0, bus.rsp_err}, 32'd0);
         cyc();
      end
      rst = 1'b0;
      p_valid[0] = 1'b0;
      p_valid[1] = 1'b0;

      // Simultaneous SUB on 0 and SLT on 1; port 0 first, port 1 three cycles later
      set_req(0, 5'b00010, 32'd10, 32'd3);
      set_req(1, 5'b00100, 32'hFFFF_FFFF, 32'd1);
      for (int k = 0; k < 6; k++) begin
         settle();
         if (k == 0) chk("sim_first_grant", {31'd0, bus.req0_ready}, 32'd1);
         if (k == 2) chk("sim_res0", bus.rsp_res, 32'd7);
         if (k == 3) chk("sim_grant1", {31'd0, bus.req1_ready}, 32'd1);
         if (k == 5) chk("sim_res1", bus.rsp_res, 32'd1);
         cyc();
      end

      // Single ADD 5+7 on port 0
      set_req(0, 5'b00000, 32'd5, 32'd7);
      settle();
      chk("add_ready", {31'd0, bus.req0_ready}, 32'd1);
      cyc();
      settle();
      chk("add_alu_src1", bus.alu_src1, 32'd7);
      cyc();
      settle();
      chk("add_res", bus.rsp_res, 32'd12);
      chk("add_rsp1_low", {31'd0, bus.rsp1_valid}, 32'd0);
      cyc();

      // Backpressure on port 0 while port 1 waits
      set_req(0, 5'b01010, 32'h0F0F_0000, 32'h0000_00F0);
      rr[0] = 1'b0;
      cyc();
      set_req(1, 5'b10001, 32'd99, 32'd0);
      cyc();
      settle();
      held_res = bus.rsp_res;
      for (int k = 0; k < 5; k++) begin
         settle();
         chk("bp_res_stable", bus.rsp_res, held_res);
         chk("bp_rdy1_low", {31'd0, bus.req1_ready}, 32'd0);
         cyc();
      end
      rr[0] = 1'b1;
      settle();
      chk("bp_rdy1_still_low", {31'd0, bus.req1_ready}, 32'd0);
      cyc();
      settle();
      chk("bp_rdy1_after", {31'd0, bus.req1_ready}, 32'd1);
      repeat (3) cyc();

      // Illegal opcode on port 1, then a legal one
      set_req(1, 5'b00001, 32'd3, 32'd4);
      repeat (2) cyc();
      settle();
      chk("ill_res", bus.rsp_res, 32'd0);
      chk("ill_err", {31'd0, bus.rsp_err}, 32'd1);
      cyc();
      set_req(1, 5'b01001, 32'hFF, 32'h3C);
      repeat (2) cyc();
      settle();
      chk("legal_err", {31'd0, bus.rsp_err}, 32'd0);
      cyc();

      // Reset during EXEC drops the operation
      set_req(0, 5'b00000, 32'd1, 32'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      for (int k = 0; k < 4; k++) begin
         settle();
         chk("drop_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
         cyc();
      end
      set_req(0, 5'b01011, 32'hF0, 32'hFF);
      repeat (2) cyc();
      settle();
      chk("xor_res", bus.rsp_res, 32'h0F);
      cyc();

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst   = ($urandom_range(0, 149) == 0);
         rr[0] = ($urandom_range(0, 3) != 0);
         rr[1] = ($urandom_range(0, 3) != 0);
         for (int n = 0; n < 2; n++) begin
            if (!p_valid[n] && $urandom_range(0, 2) != 0) begin
               p_valid[n] = 1'b1;
               p_op[n]    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(0, 31))
                                                        : legal_ops[$urandom_range(0, 11)];
               p_src0[n]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
               p_src1[n]  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            end
         end
         cyc();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
